// File: rtl/fifo_pkg.sv
// Shared FIFO package: word width default, skid-buffer depth and the
// pointer helper used by both the read-side stream and the write-side code.
package fifo_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int BUF_DEPTH = 3;
  localparam int PTR_W     = 2;

  typedef logic [PTR_W-1:0] ptr_t;

  // Advance a buffer pointer, wrapping from the last entry (2) back to 0.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(BUF_DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Three-entry circular skid buffer for the FIFO read stream.
// Holds prefetched words; head feeds the output, tail takes captured words.
module fifo_rd_skid_buf
  import fifo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             rd_clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [1:0]       level
);

  logic [WIDTH-1:0] mem [0:BUF_DEPTH-1];
  ptr_t             head;
  ptr_t             tail;

  // Storage, pointers and occupancy; clear empties the buffer without
  // touching the stored words.
  always_ff @(posedge rd_clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      level <= '0;
      // NOTE: the storage is reset as well so the head word reads 0 straight
      // out of reset; with only three entries this is cheap.
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clear) begin
      head  <= '0;
      tail  <= '0;
      level <= '0;
    end else begin
      if (wr_en) begin
        mem[tail] <= wr_data;
        tail      <= ptr_inc(tail);
      end
      if (rd_en) begin
        head <= ptr_inc(head);
      end
      case ({wr_en, rd_en})
        2'b10:   level <= level + 2'd1;
        2'b01:   level <= level - 2'd1;
        default: level <= level;
      endcase
    end
  end

  assign rd_data = mem[head];

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side consumer of the asynchronous FIFO: pops words and presents them
// as a first-word-fall-through valid/ready stream through a 3-entry skid
// buffer. Pop requests never depend on out_ready.
// Optional statistics counters are built when FIFO_RD_STREAM_STATS_EN is
// defined; otherwise word_cnt and stall_cnt are tied to 0.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 16
) (
  input  logic             rd_clk,
  input  logic             reset,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_rd_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       level,
  output logic [CNT_W-1:0] word_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  logic       inflight;
  logic       capture;
  logic       accept;
  logic [2:0] committed;

  // Words already owned by this block: buffered plus the one on its way.
  assign committed = {1'b0, level} + {2'b00, inflight};

  // Pop only when a slot is guaranteed for the returning word; held low in
  // reset so no pop is issued while the FIFO itself is being reset.
  assign fifo_rd_en = !reset && !fifo_empty && !flush &&
                      (committed < 3'(BUF_DEPTH));

  // A word arriving during a flush belongs to the discarded stream.
  assign capture   = inflight && !flush;
  assign out_valid = (level != 2'd0);
  assign accept    = out_valid && out_ready;

  // Track the pop issued last cycle; its data arrives this cycle.
  always_ff @(posedge rd_clk or posedge reset) begin
    if (reset) begin
      inflight <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples its inputs as they were before the edge.
      inflight <= fifo_rd_en;
    end
  end

  fifo_rd_skid_buf #(
    .WIDTH (WIDTH)
  ) u_skid (
    .rd_clk  (rd_clk),
    .reset   (reset),
    .clear   (flush),
    .wr_en   (capture),
    .wr_data (fifo_rd_data),
    .rd_en   (accept),
    .rd_data (out_data),
    .level   (level)
  );

`ifdef FIFO_RD_STREAM_STATS_EN
  // Saturating delivery and starvation counters; flush leaves them intact.
  always_ff @(posedge rd_clk or posedge reset) begin
    if (reset) begin
      word_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (accept && (word_cnt != '1)) begin
        word_cnt <= word_cnt + CNT_W'(1);
      end
      if (out_ready && !out_valid && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end
`else
  assign word_cnt  = '0;
  assign stall_cnt = '0;
`endif

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Read-side consumer for the team's asynchronous FIFO; lives entirely in the read clock domain.
- Pops words from the FIFO read port and presents them as a valid/ready stream with first-word-fall-through behaviour.
- Holds prefetched words in a 3-entry skid buffer, so full throughput needs no combinational out_ready -> fifo_rd_en path.
- Sits between the FIFO read port and downstream consumers such as packet parsers and UART/SPI transmitters.

Parameters:
- WIDTH, 8, data word width; must equal the FIFO WIDTH.
- CNT_W, 16, width of the statistics counters (used only with the optional feature).

Ports:
- rd_clk  in  1  read-domain clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- fifo_empty  in  1  FIFO read-side empty flag, already synchronous to rd_clk.
- fifo_rd_en  out  1  pop request to the FIFO; one word popped per high cycle.
- fifo_rd_data  in  WIDTH  FIFO read data; valid exactly 1 cycle after fifo_rd_en.
- flush  in  1  synchronous discard of buffered and in-flight words.
- out_valid  out  1  stream word available.
- out_ready  in  1  downstream accepts the word.
- out_data  out  WIDTH  stream data, driven from the buffer head.
- level  out  2  current buffer occupancy, 0..3.
- word_cnt  out  CNT_W  words delivered (optional feature).
- stall_cnt  out  CNT_W  cycles with out_ready=1 and out_valid=0 (optional feature).

Behaviour:
- Reset state (async, immediate): buffer empty, level=0, out_valid=0, out_data=0, fifo_rd_en=0, in-flight flag cleared, counters=0.
- in-flight flag: registered copy of fifo_rd_en.
- Pop/issue rule (combinational from registers and fifo_empty only): fifo_rd_en = !fifo_empty && !flush && (level + inflight) < 3.
  - fifo_rd_en never depends on out_ready.
  - Since inflight <= 1, the buffer can never overflow.
- Capture: when inflight=1 and no flush this cycle, fifo_rd_data is written at the buffer tail on the clock edge.
- Buffer: 3-entry circular buffer with 2-bit head and tail pointers, each wrapping 2 -> 0 (not at 3).
- out_valid = (level != 0); out_data = mem[head].
- Accept = out_valid && out_ready; on accept, head advances.
- Capture and accept in the same cycle: level is unchanged; both pointers advance.
- Latency: fifo_rd_en at cycle t, data at t+1, out_valid at t+2 (first word, empty buffer).
- Steady state with out_ready held high and FIFO non-empty: one word per cycle.
- Ordering is strictly preserved; there is no drop path except flush.
- out_ready low: the buffer fills to 3 and fifo_rd_en stays 0; out_data holds stable while out_valid=1 and out_ready=0.
- fifo_empty rises with a pop pending: no new pop; the pending in-flight word is still captured.
- flush=1: level cleared, pointers reset to 0, no pop that cycle, and any in-flight word (data arriving the next cycle) is discarded.
  - out_valid is 0 the cycle after flush.
  - Counters are not cleared by flush.
- Reset mid-operation: any in-flight word is lost. The FIFO is reset by the same reset, so no recovery is needed.

Optional Feature:
- Macro: FIFO_RD_STREAM_STATS_EN.
- Defined:
  - word_cnt increments on each accept.
  - stall_cnt increments on each cycle with out_ready=1 and out_valid=0.
  - Both saturate at all-ones (no wrap) and reset to 0.
- Undefined: word_cnt and stall_cnt are tied to 0 and no counter flops are built; the port list is unchanged.

Decomposition:
- Shared package fifo_pkg: WIDTH default, BUF_DEPTH=3, pointer width constant 2, and a ptr_inc function implementing the 2->0 wrap.
- The same package is to be used by the write-side FIFO code.
- One sub-module is natural: fifo_rd_skid_buf (3-entry storage plus head/tail/level); the top keeps the issue logic, in-flight tracking, flush and stats.

Test Plan:
- Reset asserted mid-stream with level=2 -> out_valid, level and fifo_rd_en go 0 immediately, with no clock needed.
- FIFO preloaded with 0x01..0x08, out_ready=1 constant -> out_valid high from cycle 2 onward; 0x01..0x08 delivered on consecutive cycles; fifo_rd_en high 8 cycles.
- 5 words available, out_ready=0 -> fifo_rd_en pulses exactly 3 times; level=3; out_data=first word, stable. Then out_ready=1 -> remaining words delivered in order with no gap.
- out_ready toggled 1,0,1,0 on a continuous stream -> no word lost or duplicated, order preserved; checked by scoreboard over 1000 random words.
- flush asserted the cycle after a pop with level=2 -> next cycle out_valid=0 and level=0; the arriving in-flight word is never output; the next delivered word is the one following it.
- FIFO_RD_STREAM_STATS_EN defined, 10 accepts and 4 idle-ready cycles -> word_cnt=10, stall_cnt=4. With CNT_W=4 and 20 accepts, word_cnt saturates at 15.
